// File: rtl/led_disp_pkg.sv
// ---------------------------------------------------------------------------
// led_disp_pkg
// Shared constants and helpers for the keypad-entry LED display scanner.
//   KEY_NONE   : keypad code meaning "no key pressed"
//   KEY_CLR    : clears the whole entry buffer
//   KEY_BS     : backspace, drops the most recently entered digit
//   BLANK_CODE : buffer code for an empty slot (decodes to all segments off)
//   SEG_BLANK  : segment pattern with every segment off
//   clog2()    : width helper for counters and indices
// ---------------------------------------------------------------------------
package led_disp_pkg;

    localparam logic [3:0] KEY_NONE   = 4'hF;
    localparam logic [3:0] KEY_CLR    = 4'hB;
    localparam logic [3:0] KEY_BS     = 4'hE;
    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [6:0] SEG_BLANK  = 7'h00;

    // Ceiling log2, never below 1 so that a single-value counter still
    // gets a one-bit register instead of a zero-width vector.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// Combinational hex-to-7-segment decoder. Codes 0-9 and A-E show their hex
// glyphs; code F is the empty-slot marker and shows nothing.
// Ports:
//   code_i : 4-bit digit code
//   seg_o  : segment pattern, bit 0 = a ... bit 6 = g, active-high
// ---------------------------------------------------------------------------
module seg7_decode
    import led_disp_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            4'h0:    seg_o = 7'h3F;
            4'h1:    seg_o = 7'h06;
            4'h2:    seg_o = 7'h5B;
            4'h3:    seg_o = 7'h4F;
            4'h4:    seg_o = 7'h66;
            4'h5:    seg_o = 7'h6D;
            4'h6:    seg_o = 7'h7D;
            4'h7:    seg_o = 7'h07;
            4'h8:    seg_o = 7'h7F;
            4'h9:    seg_o = 7'h6F;
            4'hA:    seg_o = 7'h77;
            4'hB:    seg_o = 7'h7C;
            4'hC:    seg_o = 7'h39;
            4'hD:    seg_o = 7'h5E;
            4'hE:    seg_o = 7'h79;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/led_disp_scan.sv
// ---------------------------------------------------------------------------
// led_disp_scan
// Keypad-entry digit buffer with a multiplexed 7-segment scan. One code is
// accepted per key press (no auto-repeat); KEY_CLR empties the buffer and
// KEY_BS removes the latest digit. The buffer is scanned onto an active-low
// digit-select bus and is also exported raw for downstream compare logic.
//
// Parameters:
//   NUM_DIGITS : buffer slots / scanned positions (1..SEL_W)
//   SEL_W      : physical digit-select bus width, unused bits held 1
//   SCAN_DIV   : clock cycles per scan slot (>= 1)
//   DP_POS     : slot that shows the decimal point (>= NUM_DIGITS disables)
// Ports:
//   clk        : system clock
//   rst_n      : synchronous reset, active-low
//   key        : keypad code, 4'hF = no key
//   select     : digit select, active-low one-hot, registered
//   segment7x  : segments a..g (bit 0 = a), active-high, registered
//   dp         : decimal point, active-high, registered
//   number_out : raw buffer, digit 0 in [3:0]
//   entry_cnt  : digits entered, saturates at NUM_DIGITS
// Build option:
//   LEADING_ZERO_BLANK_EN : blank leading zeros in slots above DP_POS
// ---------------------------------------------------------------------------
module led_disp_scan
    import led_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int SEL_W      = 8,
    parameter int SCAN_DIV   = 1,
    parameter int DP_POS     = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [3:0]                          key,
    output logic [SEL_W-1:0]                    select,
    output logic [6:0]                          segment7x,
    output logic                                dp,
    output logic [4*NUM_DIGITS-1:0]             number_out,
    output logic [clog2(NUM_DIGITS+1)-1:0]      entry_cnt
);

    localparam int CNT_W = clog2(NUM_DIGITS + 1);
    localparam int IDX_W = clog2(NUM_DIGITS);
    localparam int PRE_W = clog2(SCAN_DIV);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    logic [4*NUM_DIGITS-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [3:0]              key_prev_q;
    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;

    logic                    press;
    logic [3:0]              code_mux;
    logic [6:0]              dec_seg;
    logic                    lz_blank;

    // Entry buffer: a press is a transition from "no key" to a real code, so
    // holding a key or sliding directly from one key to another is ignored.
    always_comb begin
        press = (key_prev_q == KEY_NONE) && (key != KEY_NONE);
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (press) begin
            if (key == KEY_CLR) begin
                buf_d = {NUM_DIGITS{BLANK_CODE}};
                cnt_d = '0;
            end else if (key == KEY_BS) begin
                for (int i = 0; i < NUM_DIGITS - 1; i++) begin
                    buf_d[4*i +: 4] = buf_q[4*(i+1) +: 4];
                end
                buf_d[4*(NUM_DIGITS-1) +: 4] = BLANK_CODE;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end else begin
                for (int i = 1; i < NUM_DIGITS; i++) begin
                    buf_d[4*i +: 4] = buf_q[4*(i-1) +: 4];
                end
                buf_d[3:0] = key;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // Scan position: the prescaler sets how long each digit stays lit.
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == PRE_LAST) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Buffer slot currently being scanned.
    always_comb begin
        code_mux = BLANK_CODE;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                code_mux = buf_q[4*i +: 4];
            end
        end
    end

    seg7_decode u_seg7_decode (
        .code_i (code_mux),
        .seg_o  (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // A zero is "leading" when every slot above it is zero or empty; only
    // slots left of the decimal point are candidates so "0.5" keeps its 0.
    always_comb begin
        lz_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((idx_q == IDX_W'(i)) && (i > DP_POS)) begin
                lz_blank = (buf_q[4*i +: 4] == 4'h0);
                for (int j = i + 1; j < NUM_DIGITS; j++) begin
                    if ((buf_q[4*j +: 4] != 4'h0) && (buf_q[4*j +: 4] != BLANK_CODE)) begin
                        lz_blank = 1'b0;
                    end
                end
            end
        end
    end
`else
    always_comb begin
        lz_blank = 1'b0;
    end
`endif

    // Pin values for the current slot; bits beyond NUM_DIGITS stay off.
    always_comb begin
        for (int i = 0; i < SEL_W; i++) begin
            sel_d[i] = !((i < NUM_DIGITS) && (idx_q == IDX_W'(i)));
        end
        seg_d = lz_blank ? SEG_BLANK : dec_seg;
        dp_d  = (DP_POS < NUM_DIGITS) && (int'(idx_q) == DP_POS);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q      <= {NUM_DIGITS{BLANK_CODE}};
            cnt_q      <= '0;
            key_prev_q <= KEY_NONE;
            presc_q    <= '0;
            idx_q      <= '0;
            sel_q      <= '1;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            key_prev_q <= key;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign select     = sel_q;
    assign segment7x  = seg_q;
    assign dp         = dp_q;
    assign number_out = buf_q;
    assign entry_cnt  = cnt_q;

endmodule

// File: tb/tb_led_disp_scan.sv
module tb_led_disp_scan;

    localparam int ND   = 3;
    localparam int SW   = 8;
    localparam int SDIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam int DPP  = 0;
`else
    localparam int DPP  = 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      key = 4'hF;
    logic [SW-1:0]   select;
    logic [6:0]      segment7x;
    logic            dp;
    logic [4*ND-1:0] number_out;
    logic [1:0]      entry_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    led_disp_scan #(
        .NUM_DIGITS (ND),
        .SEL_W      (SW),
        .SCAN_DIV   (SDIV),
        .DP_POS     (DPP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key        (key),
        .select     (select),
        .segment7x  (segment7x),
        .dp         (dp),
        .number_out (number_out),
        .entry_cnt  (entry_cnt)
    );

    always #5 clk = ~clk;

    // Clock edges since reset was released.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [6:0] glyph(input logic [3:0] c);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h00};
        return t[c];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_key(input logic [3:0] k, input int hold);
        key = k;
        repeat (hold) tick();
        key = 4'hF;
        repeat (2) tick();
    endtask

    // Watch the scan for n cycles; segs holds expected patterns for slots 2,1,0.
    task automatic scan_check(input string name, input logic [20:0] segs, input int n);
        int idx;
        logic [SW-1:0] esel;
        logic [6:0] eseg;
        for (int c = 0; c < n; c++) begin
            tick();
            idx  = ((cyc - 1) / SDIV) % ND;
            esel = '1;
            esel[idx] = 1'b0;
            eseg = segs[7*idx +: 7];
            chk({name, ".select"}, 32'(select), 32'(esel));
            chk({name, ".dp"}, 32'(dp), 32'(idx == DPP));
            chk({name, ".seg"}, 32'(segment7x), 32'(eseg));
        end
    endtask

    typedef struct {
        logic [3:0]  k;
        int          hold;
        logic [11:0] num;
        logic [1:0]  cnt;
    } vec_t;

    vec_t vecs [15];

    initial begin
        vecs[0]  = '{4'h1, 5,  12'hFF1, 2'd1};
        vecs[1]  = '{4'h2, 5,  12'hF12, 2'd2};
        vecs[2]  = '{4'h3, 5,  12'h123, 2'd3};
        vecs[3]  = '{4'h4, 30, 12'h234, 2'd3};
        vecs[4]  = '{4'h5, 5,  12'h345, 2'd3};
        vecs[5]  = '{4'hE, 5,  12'hF34, 2'd2};
        vecs[6]  = '{4'hE, 3,  12'hFF3, 2'd1};
        vecs[7]  = '{4'hE, 3,  12'hFFF, 2'd0};
        vecs[8]  = '{4'hE, 3,  12'hFFF, 2'd0};
        vecs[9]  = '{4'h0, 2,  12'hFF0, 2'd1};
        vecs[10] = '{4'hA, 2,  12'hF0A, 2'd2};
        vecs[11] = '{4'hB, 2,  12'hFFF, 2'd0};
        vecs[12] = '{4'h7, 1,  12'hFF7, 2'd1};
        vecs[13] = '{4'hC, 4,  12'hF7C, 2'd2};
        vecs[14] = '{4'hD, 4,  12'h7CD, 2'd3};

        // Reset state
        rst_n = 1'b0;
        key   = 4'hF;
        repeat (3) tick();
        chk("rst.select", 32'(select), 32'hFF);
        chk("rst.seg", 32'(segment7x), 32'h00);
        chk("rst.dp", 32'(dp), 32'h0);
        chk("rst.number", 32'(number_out), 32'hFFF);
        chk("rst.cnt", 32'(entry_cnt), 32'h0);
        rst_n = 1'b1;

        // Entry, hold without repeat, overflow, backspace, clear
        foreach (vecs[i]) begin
            press_key(vecs[i].k, vecs[i].hold);
            chk($sformatf("vec%0d.number", i), 32'(number_out), 32'(vecs[i].num));
            chk($sformatf("vec%0d.cnt", i), 32'(entry_cnt), 32'(vecs[i].cnt));
        end

        // Scan of buffer 7CD: slot0=D, slot1=C, slot2=7
        scan_check("scan7CD", {glyph(4'h7), glyph(4'hC), glyph(4'hD)}, 24);

        // Direct key change 4 -> 5 without release counts once
        press_key(4'hB, 2);
        key = 4'h4;
        repeat (3) tick();
        key = 4'h5;
        repeat (3) tick();
        key = 4'hF;
        repeat (2) tick();
        chk("slide.number", 32'(number_out), 32'hFF4);
        chk("slide.cnt", 32'(entry_cnt), 32'd1);

        // Single-edge latency from press to buffer
        press_key(4'hB, 2);
        key = 4'h9;
        tick();
        chk("lat.number", 32'(number_out), 32'hFF9);
        chk("lat.cnt", 32'(entry_cnt), 32'd1);
        key = 4'hF;
        repeat (2) tick();

        // Reset in the middle of an entry
        press_key(4'hB, 2);
        press_key(4'h1, 2);
        press_key(4'h2, 2);
        chk("mid.pre", 32'(number_out), 32'hF12);
        rst_n = 1'b0;
        tick();
        chk("mid.number", 32'(number_out), 32'hFFF);
        chk("mid.cnt", 32'(entry_cnt), 32'd0);
        chk("mid.select", 32'(select), 32'hFF);
        rst_n = 1'b1;

        // Leading zeros: 005
        press_key(4'h0, 2);
        press_key(4'h0, 2);
        press_key(4'h5, 2);
        chk("lz.number", 32'(number_out), 32'h005);
`ifdef LEADING_ZERO_BLANK_EN
        scan_check("lz", {7'h00, 7'h00, glyph(4'h5)}, 12);
`else
        scan_check("lz", {glyph(4'h0), glyph(4'h0), glyph(4'h5)}, 12);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
